// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-enabled h/v counters with registered sync, visible and strobe decode.
// Latency: outputs are flops loaded from the next counter values; there is no backpressure and pix_en only gates advance.
// Optional VGA_FRAME_COUNT_EN adds a 10-bit frame counter that is registered alongside frame_start.
module vga_timing_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
`ifdef VGA_FRAME_COUNT_EN
  output logic [9:0] frame_count,
`endif
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS_END  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       vis_nxt;

  // Next counter values; hpos/vpos are themselves the state registers.
  always_comb begin
    h_nxt  = hpos;
    v_nxt  = vpos;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (pix_en) begin
      if (hpos == H_LAST) begin
        h_nxt  = '0;
        h_wrap = 1'b1;
        if (vpos == V_LAST) begin
          v_nxt  = '0;
          v_wrap = 1'b1;
        end else begin
          v_nxt = vpos + 10'd1;
        end
      end else begin
        h_nxt = hpos + 10'd1;
      end
    end
  end

  // Decode from the next values so every registered output lines up with hpos/vpos.
  always_comb begin
    hs_nxt  = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_nxt  = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vis_nxt = (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      visible     <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      visible     <= vis_nxt;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Animation time base; advances on the same edge that raises frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (v_wrap) begin
      frame_count <= frame_count + 10'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance plus a tiny-raster instance so whole frames fit the run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
  logic d_hsync, d_vsync, d_visible, d_ls, d_fs;
  logic s_hsync, s_vsync, s_visible, s_ls, s_fs;
`ifdef VGA_FRAME_COUNT_EN
  logic [9:0] d_fc, s_fc;
`endif

  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
`ifdef VGA_FRAME_COUNT_EN
    .frame_count(d_fc),
`endif
    .hpos(d_hpos), .vpos(d_vpos), .hsync(d_hsync), .vsync(d_vsync),
    .visible(d_visible), .line_start(d_ls), .frame_start(d_fs)
  );

  // Small raster: H 4+1+2+1 = 8, V 3+1+1+2 = 7, so 56 clks per frame.
  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .SYNC_ACTIVE(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
`ifdef VGA_FRAME_COUNT_EN
    .frame_count(s_fc),
`endif
    .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
    .visible(s_visible), .line_start(s_ls), .frame_start(s_fs)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int hpos, vpos, hsync, vsync, visible, ls, fs, fc;
  } exp_t;

  // Reference: raster position is a pure function of how many enabled edges have elapsed since reset.
  function automatic exp_t model(input longint t, input bit prev_en,
                                 input int hd, input int hf, input int hs, input int hb,
                                 input int vd, input int vf, input int vs, input int vb);
    exp_t e;
    longint ht, vt, line;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    e.hpos    = int'(t % ht);
    line      = t / ht;
    e.vpos    = int'(line % vt);
    e.hsync   = (e.hpos >= hd + hf && e.hpos < hd + hf + hs) ? 0 : 1;
    e.vsync   = (e.vpos >= vd + vf && e.vpos < vd + vf + vs) ? 0 : 1;
    e.visible = (e.hpos < hd && e.vpos < vd) ? 1 : 0;
    e.ls      = (prev_en && t > 0 && e.hpos == 0) ? 1 : 0;
    e.fs      = (e.ls == 1 && e.vpos == 0) ? 1 : 0;
    e.fc      = int'((t / (ht * vt)) % 1024);
    return e;
  endfunction

  longint t_edges;
  bit last_en;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_edges <= 0;
      last_en <= 1'b0;
    end else begin
      last_en <= pix_en;
      if (pix_en) t_edges <= t_edges + 1;
    end
  end

  exp_t ed, es;
  always @(negedge clk) begin
    ed = model(t_edges, last_en, 640, 16, 96, 48, 480, 10, 2, 33);
    es = model(t_edges, last_en, 4, 1, 2, 1, 3, 1, 1, 2);
    chk("d_hpos", int'(d_hpos), ed.hpos);
    chk("d_vpos", int'(d_vpos), ed.vpos);
    chk("d_hsync", int'(d_hsync), ed.hsync);
    chk("d_vsync", int'(d_vsync), ed.vsync);
    chk("d_visible", int'(d_visible), ed.visible);
    chk("d_line_start", int'(d_ls), ed.ls);
    chk("d_frame_start", int'(d_fs), ed.fs);
    chk("s_hpos", int'(s_hpos), es.hpos);
    chk("s_vpos", int'(s_vpos), es.vpos);
    chk("s_hsync", int'(s_hsync), es.hsync);
    chk("s_vsync", int'(s_vsync), es.vsync);
    chk("s_visible", int'(s_visible), es.visible);
    chk("s_line_start", int'(s_ls), es.ls);
    chk("s_frame_start", int'(s_fs), es.fs);
`ifdef VGA_FRAME_COUNT_EN
    chk("d_frame_count", int'(d_fc), ed.fc);
    chk("s_frame_count", int'(s_fc), es.fc);
`endif
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hpos"}, int'(d_hpos), 0);
    chk({tag, "_vpos"}, int'(d_vpos), 0);
    chk({tag, "_hsync"}, int'(d_hsync), 1);
    chk({tag, "_vsync"}, int'(d_vsync), 1);
    chk({tag, "_visible"}, int'(d_visible), 1);
    chk({tag, "_line_start"}, int'(d_ls), 0);
    chk({tag, "_frame_start"}, int'(d_fs), 0);
    chk({tag, "_s_hpos"}, int'(s_hpos), 0);
    chk({tag, "_s_vpos"}, int'(s_vpos), 0);
  endtask

  int hs_low, vis_s, vs_low_s, ls_cnt, fs_cnt;

  initial begin
    #12;
    chk_reset_vals("reset");

    // One full default line with pix_en held high.
    @(negedge clk);
    rst_n  = 1'b1;
    pix_en = 1'b1;
    hs_low = 0; vis_s = 0; vs_low_s = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (!d_hsync) hs_low++;
      if (d_ls) ls_cnt++;
      if (d_fs) fs_cnt++;
      if (i < 56) begin
        if (s_visible) vis_s++;
        if (!s_vsync) vs_low_s++;
      end
      @(negedge clk);
    end
    chk("line_hsync_low_clks", hs_low, 96);
    chk("line_ls_before_wrap", ls_cnt, 0);
    chk("line_fs_count", fs_cnt, 0);
    chk("small_frame_visible_clks", vis_s, 12);
    chk("small_frame_vsync_low_clks", vs_low_s, 8);
    chk("wrap_hpos", int'(d_hpos), 0);
    chk("wrap_vpos", int'(d_vpos), 1);
    chk("wrap_line_start", int'(d_ls), 1);

    // Random enable pattern, then strict alternation.
    repeat (3000) begin
      pix_en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    for (int i = 0; i < 40; i++) begin
      pix_en = (i % 2 == 0);
      @(negedge clk);
    end

    // Reset asynchronously mid-line while hsync is asserted.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    pix_en = 1'b1;
    repeat (700) @(negedge clk);
    chk("pre_reset_hpos", int'(d_hpos), 700);
    chk("pre_reset_hsync", int'(d_hsync), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_adv_hpos", int'(d_hpos), 1);
    chk("first_adv_ls", int'(d_ls), 0);

    // Advance to the third small-raster frame boundary (t = 168).
    repeat (167) @(negedge clk);
    chk("s_frame3_hpos", int'(s_hpos), 0);
    chk("s_frame3_vpos", int'(s_vpos), 0);
    chk("s_frame3_fs", int'(s_fs), 1);
    chk("s_frame3_ls", int'(s_ls), 1);
`ifdef VGA_FRAME_COUNT_EN
    chk("s_frame_count_3", int'(s_fc), 3);
    repeat (1020 * 56) @(negedge clk);
    chk("s_frame_count_1023", int'(s_fc), 1023);
    repeat (56) @(negedge clk);
    chk("s_frame_count_wrap", int'(s_fc), 0);
    chk("s_wrap_fs", int'(s_fs), 1);
`endif

    pix_en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator: the source end of the hpos/vpos/visible/hsync/vsync interface consumed by the pixel colour path.
- Holds free-running horizontal and vertical counters, advanced by a pixel-rate enable.
- Decodes sync pulses, the visible window, and line/frame strobes.
- Drives the VGA connector syncs and the colour pipeline in the demoscene top level.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low, which matches 640x480@60)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pix_en  input  1  pixel tick; the counters advance only on clk edges where pix_en=1
- hpos  output  10  horizontal position, 0..H_TOTAL-1
- vpos  output  10  vertical position, 0..V_TOTAL-1
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- visible  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- line_start  output  1  one-clk strobe when hpos wraps to 0
- frame_start  output  1  one-clk strobe when hpos and vpos both wrap to 0

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525). Both must be ≤1024 so they fit 10 bits.
- Reset (rst_n=0, async): hpos=0, vpos=0, visible=1, hsync=vsync=~SYNC_ACTIVE, line_start=0, frame_start=0.
- Reset is released synchronously into the counting logic. The first advance happens on the first pix_en=1 edge after release.
- All outputs are flops, computed from the next counter values. On every cycle, hpos/vpos/hsync/vsync/visible are mutually consistent, with zero relative skew.
- Counter update on a pix_en=1 edge:
  - If hpos=H_TOTAL-1: hpos←0, and vpos←(vpos=V_TOTAL-1 ? 0 : vpos+1).
  - Otherwise: hpos←hpos+1 and vpos holds.
- pix_en=0: all counters and decoded levels hold. line_start and frame_start go to 0 on that edge.
- hsync = SYNC_ACTIVE iff H_DISPLAY+H_FRONT ≤ hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751). Otherwise hsync = ~SYNC_ACTIVE.
- vsync = SYNC_ACTIVE iff V_DISPLAY+V_FRONT ≤ vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491). This depends on vpos only, so vsync toggles at hpos=0 of the affected line.
- line_start: 1 for exactly one clk after the pix_en edge that set hpos to 0. Otherwise 0.
- frame_start: 1 for exactly one clk after the pix_en edge that set both hpos and vpos to 0. Otherwise 0. frame_start implies line_start in the same cycle.
- Reset mid-frame: the counters return to (0,0) immediately with no strobe. The strobes are not asserted out of reset.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- When defined:
  - Adds output frame_count[9:0], reset to 0.
  - It increments (mod 1024) on each edge that asserts frame_start, and is registered together with frame_start.
  - It serves as the animation time base for the colour path, replacing the vsync-edge clocked counter.
- When undefined: the port and logic are absent, and the block's behaviour is otherwise identical.

Test Plan:
- Reset, then pix_en held 1 for 800 clks: hpos runs 0..799 then 0; vpos goes 0→1 at the wrap; line_start is high for 1 clk at the wrap; frame_start stays 0.
- Full frame (420000 enabled clks): vpos wraps 524→0 together with hpos 799→0; frame_start and line_start are both high for that single clk; visible is high for exactly 640×480 = 307200 clks.
- Sync decode at defaults: hsync low for exactly hpos 656..751 (96 clks/line); vsync low for vpos 490..491 (1600 clks), rising when vpos becomes 492.
- pix_en toggling 1,0,1,0: hpos advances once per two clks; the strobes last 1 clk even when the following clk has pix_en=0.
- Async reset asserted at hpos=700, vpos=300 between clk edges: outputs go to reset values immediately, without waiting for a clk edge; the first enabled edge after release gives hpos=1.
- With VGA_FRAME_COUNT_EN and 3 full frames: frame_count=3; starting from a preload near 1023, it wraps 1023→0.
